rr_mux_reg: RTL and testbench
=============================

Name: rr_mux_reg

Overview:
- Parametrised N-channel, WIDTH-bit data selector; the successor of the 16-bit 2:1 combinational select.
- Adds a registered output stage, valid/ready handshakes per channel, and a run-time choice between explicit select and round-robin arbitration.
- Sits between multiple producers (register-file read paths, immediate/ALU sources, future multi-master buses) and one consumer.
- Carries the winning channel index with the data.

Parameters:
- WIDTH, 16, data width per channel.
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), width of select/index fields (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = explicit select via sel, 1 = round-robin arbitration.
- sel  input  SELW  channel index used when mode = 0.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; combinational; at most one bit set.
- out_valid  output  1  registered output holds a word.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SELW  registered index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts the output word this cycle.

Behaviour:
- Reset (rst = 1 at a clock edge): out_valid = 0, out_data = 0, out_sel = 0, rr pointer ptr = N-1. In-flight word is discarded. in_ready is all 0 while rst = 1.
- load_en = !out_valid || out_ready. This is a single-entry pipeline register with full throughput: one word per cycle when out_ready is held high.
- Grant, mode 0:
  - g = sel. in_ready[sel] = load_en; all other bits are 0.
  - If sel >= N, there is no grant, in_ready = 0, and nothing loads.
- Grant, mode 1:
  - g = the first channel i with in_valid[i] = 1, searching (ptr+1) mod N, (ptr+2) mod N, ... and wrapping.
  - in_ready[g] = load_en; all other bits are 0.
  - No valid channel means no grant.
- Transfer: occurs when in_valid[g] && in_ready[g]. At the next edge: out_data <= channel g data, out_sel <= g, out_valid <= 1. In mode 1, ptr <= g as well.
- No transfer and out_ready = 1: out_valid <= 0; out_data and out_sel hold their last values.
- No transfer and out_ready = 0 with out_valid = 1: the output holds stable (data, sel and valid unchanged).
- Latency: exactly 1 cycle from the input handshake to out_valid.
- Simultaneous output drain and new load in one cycle: the new word replaces the old one and out_valid stays 1.
- ptr updates only on mode-1 transfers. A mode-0 transfer leaves ptr unchanged.
- mode and sel are sampled every cycle. Changing them while out_valid = 1 does not disturb the held word.
- Producers must hold in_valid and in_data until their handshake completes. The block never drops an accepted word except on reset.
- in_ready depends combinationally on out_ready, mode, sel, in_valid and ptr. There is no combinational path from in_data to any output.

Decomposition:
- Shared package rr_mux_pkg holds:
  - MODE_SEL = 1'b0 and MODE_RR = 1'b1.
  - A clog2-safe width helper function.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req[N], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_any.
  - Instantiated once; reusable by later arbiters.

Test Plan:
- Reset mid-stream:
  - Stimulus: out_valid = 1, out_data = 0x00AA; assert rst for 1 cycle.
  - Response: next cycle out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0 during rst.
  - Stimulus: after reset, mode = 1 with all channels valid.
  - Response: channel 0 is granted first.
- Mode 0 select:
  - Stimulus: N = 4, ch0 = 30, ch1 = 17, all valid, out_ready = 1; sel = 0, 1, 1, 0 on successive cycles.
  - Response: out_data = 30, 17, 17, 30 one cycle later; out_sel matches; in_ready = 0001, 0010, 0010, 0001.
- Round-robin fairness:
  - Stimulus: mode = 1, all 4 channels continuously valid with data 0x10..0x13, out_ready = 1.
  - Response: out_sel sequence 0,1,2,3,0,1 with out_data 0x10,0x11,0x12,0x13,0x10,0x11; out_valid = 1 every cycle after the first.
- Sparse requests and wrap-around:
  - Stimulus: mode = 1, only ch1 and ch3 valid, starting from ptr = 3.
  - Response: grants alternate 1,3,1,3; ch0 and ch2 never see in_ready.
- Backpressure:
  - Stimulus: out_valid = 1, out_sel = 2, out_data = 0x1234; hold out_ready = 0 for 3 cycles while ch0 is valid.
  - Response: output stays 0x1234 / 2 and in_ready = 0.
  - Stimulus: release out_ready.
  - Response: ch0 data appears the next cycle.
- Out-of-range select:
  - Stimulus: N = 3, mode = 0, sel = 3, all valid.
  - Response: in_ready = 000; out_valid drops to 0 after the held word drains.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared definitions for the N-channel registered selector and its picker.
package rr_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Index width that never collapses to zero bits.
  function automatic int clog2s(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requester after ptr, wrapping modulo N.
module rr_pick import rr_mux_pkg::*; #(
  parameter int N    = 4,
  parameter int SELW = clog2s(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  always_comb begin
    int idx;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[SELW'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_reg.sv
// N-channel WIDTH-bit selector with a single-entry output register, per-channel
// valid/ready, and run-time choice of explicit select or round-robin grant.
module rr_mux_reg import rr_mux_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int N     = 4,
  parameter int SELW  = clog2s(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  logic [N-1:0][WIDTH-1:0] ch;
  logic [SELW-1:0]         ptr, rr_idx, g;
  logic                    rr_any, g_any, load_en, xfer;

  assign ch = in_data;

  rr_pick #(.N(N), .SELW(SELW)) u_pick (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign load_en = !out_valid || out_ready;

  // Explicit select grants regardless of in_valid; an index past N-1 grants nothing.
  always_comb begin
    g        = sel;
    g_any    = int'(sel) < N;
    if (mode == MODE_RR) begin
      g     = rr_idx;
      g_any = rr_any;
    end
    in_ready = '0;
    if (!rst && g_any && load_en) in_ready[g] = 1'b1;
  end

  assign xfer = g_any && in_valid[g] && in_ready[g];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= ch[g];
      out_sel   <= g;
      if (mode == MODE_RR) ptr <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Randomised and directed bench for rr_mux_reg against a rule-level model.
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        rst, mode, out_ready, out_valid;
  logic [1:0]  sel, out_sel;
  logic [3:0]  in_valid, in_ready;
  logic [63:0] in_data;
  logic [15:0] out_data;

  logic        rst3, mode3, ordy3, ov3;
  logic [1:0]  sel3, os3;
  logic [2:0]  iv3, ir3;
  logic [47:0] id3;
  logic [15:0] od3;

  int checks = 0;
  int errors = 0;

  // model state
  logic        m_v;
  logic [15:0] m_d;
  logic [1:0]  m_s;
  int          m_ptr, m_g, m_xg;
  logic [3:0]  m_rdy;

  always #5 clk = ~clk;

  rr_mux_reg #(.WIDTH(16), .N(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  rr_mux_reg #(.WIDTH(16), .N(3)) dut3 (
    .clk(clk), .rst(rst3), .mode(mode3), .sel(sel3),
    .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_sel(os3),
    .out_ready(ordy3)
  );

  // Grant: explicit index, or first valid channel scanning forward from ptr+1.
  task automatic mdl_eval();
    m_g = -1;
    if (!rst) begin
      if (mode == 1'b0) m_g = int'(sel);
      else
        for (int k = 1; k <= 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (in_valid[c]) begin m_g = c; break; end
        end
    end
    m_rdy = '0;
    if (m_g >= 0 && (!m_v || out_ready)) m_rdy[m_g] = 1'b1;
  endtask

  task automatic mdl_update();
    m_xg = -1;
    if (rst) begin
      m_v = 1'b0; m_d = '0; m_s = '0; m_ptr = 3;
    end else if (m_g >= 0 && m_rdy[m_g] && in_valid[m_g]) begin
      m_xg = m_g;
      m_v  = 1'b1;
      m_d  = in_data[m_g*16 +: 16];
      m_s  = 2'(m_g);
      if (mode) m_ptr = m_g;
    end else if (out_ready) begin
      m_v = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    mdl_update();
    #1;
  endtask

  task automatic set_ch(input int c, input logic [15:0] v);
    in_data[c*16 +: 16] = v;
  endtask

  // Entered and left just after a falling edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b1; mode = 1'b0; sel = '0;
    #1; mdl_eval();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 16'h00AA); out_ready = 1'b0;
    #1; mdl_eval();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h00AA)
      begin errors++; $display("FAIL preload: v=%b d=%h exp v=1 d=00aa", out_valid, out_data); end
    @(negedge clk);
    rst = 1'b1;
    #1; mdl_eval();
    checks++;
    if (in_ready !== 4'b0000)
      begin errors++; $display("FAIL ready_in_rst: got %b exp 0000", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || out_sel !== 2'd0)
      begin errors++; $display("FAIL reset_out: v=%b d=%h s=%0d exp 0/0000/0", out_valid, out_data, out_sel); end
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 16'(16'h0100 + c));
    #1; mdl_eval();
    checks++;
    if (in_ready !== 4'b0001)
      begin errors++; $display("FAIL rr_first: got %b exp 0001", in_ready); end
    tick();
    checks++;
    if (out_sel !== 2'd0 || out_data !== 16'h0100 || out_valid !== 1'b1)
      begin errors++; $display("FAIL rr_first_out: s=%0d d=%h exp 0/0100", out_sel, out_data); end
    @(negedge clk);
  endtask

  task automatic test_mode0();
    int         sq[4]  = '{0, 1, 1, 0};
    logic [3:0] er[4]  = '{4'b0001, 4'b0010, 4'b0010, 4'b0001};
    logic [15:0] ed[4] = '{16'd30, 16'd17, 16'd17, 16'd30};
    do_reset();
    mode = 1'b0; in_valid = 4'hF; out_ready = 1'b1;
    set_ch(0, 16'd30); set_ch(1, 16'd17); set_ch(2, 16'd99); set_ch(3, 16'd77);
    for (int i = 0; i < 4; i++) begin
      sel = 2'(sq[i]);
      #1; mdl_eval();
      checks++;
      if (in_ready !== er[i])
        begin errors++; $display("FAIL m0_ready[%0d]: got %b exp %b", i, in_ready, er[i]); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== ed[i] || out_sel !== 2'(sq[i]))
        begin errors++; $display("FAIL m0_out[%0d]: d=%0d s=%0d exp %0d/%0d", i, out_data, out_sel, ed[i], sq[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_rr_fair();
    int es[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    mode = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) set_ch(c, 16'(16'h10 + c));
    for (int i = 0; i < 6; i++) begin
      #1; mdl_eval();
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'(es[i]) || out_data !== 16'(16'h10 + es[i]))
        begin errors++; $display("FAIL rr_fair[%0d]: v=%b s=%0d d=%h exp s=%0d", i, out_valid, out_sel, out_data, es[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_sparse();
    int es[4] = '{1, 3, 1, 3};
    do_reset();
    mode = 1'b1; in_valid = 4'b1010; out_ready = 1'b1;
    set_ch(1, 16'hB1); set_ch(3, 16'hB3);
    for (int i = 0; i < 4; i++) begin
      #1; mdl_eval();
      checks++;
      if (in_ready[0] !== 1'b0 || in_ready[2] !== 1'b0 || in_ready !== m_rdy)
        begin errors++; $display("FAIL sparse_ready[%0d]: got %b exp %b", i, in_ready, m_rdy); end
      tick();
      checks++;
      if (out_sel !== 2'(es[i]))
        begin errors++; $display("FAIL sparse_sel[%0d]: got %0d exp %0d", i, out_sel, es[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; set_ch(2, 16'h1234); out_ready = 1'b0;
    #1; mdl_eval();
    tick();
    @(negedge clk);
    mode = 1'b1; in_valid = 4'b0001; set_ch(0, 16'h5555);
    for (int i = 0; i < 3; i++) begin
      #1; mdl_eval();
      checks++;
      if (in_ready !== 4'b0000)
        begin errors++; $display("FAIL bp_ready[%0d]: got %b exp 0000", i, in_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_sel !== 2'd2)
        begin errors++; $display("FAIL bp_hold[%0d]: v=%b d=%h s=%0d exp 1/1234/2", i, out_valid, out_data, out_sel); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1; mdl_eval();
    checks++;
    if (in_ready !== 4'b0001)
      begin errors++; $display("FAIL bp_release_ready: got %b exp 0001", in_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h5555 || out_sel !== 2'd0)
      begin errors++; $display("FAIL bp_release_out: d=%h s=%0d exp 5555/0", out_data, out_sel); end
    @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    in_valid = '0;
    for (int i = 0; i < 400; i++) begin
      if (m_xg >= 0) in_valid[m_xg] = 1'b0;
      for (int c = 0; c < 4; c++)
        if (!in_valid[c] && $urandom_range(0, 2) != 0) begin
          in_valid[c] = 1'b1;
          set_ch(c, 16'($urandom));
        end
      mode = 1'($urandom); sel = 2'($urandom); out_ready = ($urandom_range(0, 3) != 0);
      #1; mdl_eval();
      checks++;
      if (in_ready !== m_rdy)
        begin errors++; $display("FAIL rand_ready[%0d]: got %b exp %b", i, in_ready, m_rdy); end
      tick();
      checks++;
      if ({out_valid, out_data, out_sel} !== {m_v, m_d, m_s})
        begin errors++; $display("FAIL rand_out[%0d]: v=%b d=%h s=%0d exp v=%b d=%h s=%0d", i, out_valid, out_data, out_sel, m_v, m_d, m_s); end
      @(negedge clk);
    end
  endtask

  task automatic test_oor();
    mode3 = 1'b0; sel3 = 2'd1; iv3 = 3'b111; id3 = {16'h0C02, 16'h0BEE, 16'h0C00}; ordy3 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov3 !== 1'b1 || od3 !== 16'h0BEE || os3 !== 2'd1)
      begin errors++; $display("FAIL oor_load: v=%b d=%h s=%0d exp 1/0bee/1", ov3, od3, os3); end
    @(negedge clk);
    sel3 = 2'd3;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ir3 !== 3'b000)
        begin errors++; $display("FAIL oor_ready_hold[%0d]: got %b exp 000", i, ir3); end
      @(posedge clk); #1;
      checks++;
      if (ov3 !== 1'b1 || od3 !== 16'h0BEE)
        begin errors++; $display("FAIL oor_hold[%0d]: v=%b d=%h exp 1/0bee", i, ov3, od3); end
      @(negedge clk);
    end
    ordy3 = 1'b1;
    #1;
    checks++;
    if (ir3 !== 3'b000)
      begin errors++; $display("FAIL oor_ready_drain: got %b exp 000", ir3); end
    @(posedge clk); #1;
    checks++;
    if (ov3 !== 1'b0 || od3 !== 16'h0BEE)
      begin errors++; $display("FAIL oor_drain: v=%b d=%h exp 0/0bee", ov3, od3); end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    m_v = 1'b0; m_d = '0; m_s = '0; m_ptr = 3; m_g = -1; m_xg = -1; m_rdy = '0;
    rst3 = 1'b1; mode3 = 1'b0; sel3 = '0; iv3 = '0; id3 = '0; ordy3 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    test_reset();
    test_mode0();
    test_rr_fair();
    test_sparse();
    test_backpressure();
    test_random();
    test_oor();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
